// File: rtl/latch_write_arbiter_pkg.sv
// Shared definitions for the latch write arbiter: FSM state encoding,
// default parameter values and the enable-counter width.
package latch_write_arbiter_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned ADDR_W_DEF    = 2;
  localparam int unsigned EN_CYCLES_DEF = 1;

  // Enable-duration counter width; covers EN_CYCLES up to 15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/latch_write_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   clock, reset   - clock and synchronous active-low reset
//   enable         - arbitration allowed this cycle (owner is idle)
//   valid0/valid1  - request lines
//   grant          - winning requester index (combinational)
//   fire           - a grant is issued this cycle (combinational)
// The pointer holds the favoured requester and moves only when a grant fires.
module rr_arbiter2 (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic valid0,
  input  logic valid1,
  output logic grant,
  output logic fire
);

  logic favor;

  // Both requesting: favoured one wins; otherwise the lone requester wins.
  always_comb begin
    grant = 1'b0;
    fire  = 1'b0;
    if (valid0 && valid1) begin
      grant = favor;
    end else begin
      grant = valid1;
    end
    fire = enable && (valid0 || valid1);
  end

  // After a grant, the other requester becomes favoured.
  always_ff @(posedge clock) begin
    if (!reset) begin
      favor <= 1'b0;
    end else if (fire) begin
      favor <= ~grant;
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Arbitrates two write requesters onto an external D-latch bank and
// sequences each write as SETUP -> ENABLE (EN_CYCLES) -> HOLD.
// Ports:
//   clock, reset                 - clock and synchronous active-low reset
//   io_req{0,1}_valid/addr/data  - requester write ports
//   io_req{0,1}_ready            - accept strobe (combinational, IDLE only)
//   io_bank_addr/data            - registered word select and latch D inputs
//   io_bank_enable               - latch enable, straight from a flop
//   io_busy                      - write in progress
//   io_grant                     - owner of the current/most recent write
module latch_write_arbiter
  import latch_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned EN_CYCLES = EN_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_req0_valid,
  output logic              io_req0_ready,
  input  logic [ADDR_W-1:0] io_req0_addr,
  input  logic [DATA_W-1:0] io_req0_data,
  input  logic              io_req1_valid,
  output logic              io_req1_ready,
  input  logic [ADDR_W-1:0] io_req1_addr,
  input  logic [DATA_W-1:0] io_req1_data,
  output logic [ADDR_W-1:0] io_bank_addr,
  output logic [DATA_W-1:0] io_bank_data,
  output logic              io_bank_enable,
  output logic              io_busy,
  output logic              io_grant
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic             arb_enable;
  logic             arb_grant;
  logic             arb_fire;

  // Arbitration only in IDLE and never while reset is asserted, so both
  // readies stay low during reset.
  assign arb_enable = reset && (state == IDLE);

  rr_arbiter2 u_rr (
    .clock  (clock),
    .reset  (reset),
    .enable (arb_enable),
    .valid0 (io_req0_valid),
    .valid1 (io_req1_valid),
    .grant  (arb_grant),
    .fire   (arb_fire)
  );

  // Ready goes only to the granted requester; its valid is high by construction.
  assign io_req0_ready = arb_fire && !arb_grant;
  assign io_req1_ready = arb_fire &&  arb_grant;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; the counter holds remaining ENABLE cycles minus one.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (arb_fire) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        state_next = ENABLE;
        cnt_next   = CNT_W'(EN_CYCLES - 1);
      end
      ENABLE: begin
        if (cnt == '0) begin
          state_next = HOLD;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output registers; enable and busy are decoded from the next state so the
  // pins come straight from flops and line up with the state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      io_bank_addr   <= '0;
      io_bank_data   <= '0;
      io_bank_enable <= 1'b0;
      io_busy        <= 1'b0;
      io_grant       <= 1'b0;
    end else begin
      io_bank_enable <= (state_next == ENABLE);
      io_busy        <= (state_next != IDLE);
      if (accept) begin
        io_bank_addr <= arb_grant ? io_req1_addr : io_req0_addr;
        io_bank_data <= arb_grant ? io_req1_data : io_req0_data;
        io_grant     <= arb_grant;
      end
    end
  end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: two instances (EN_CYCLES = 1 and 3) share
// the same stimulus and are each checked every cycle against a write-timeline
// reference model (cycles elapsed since the accept).
module tb_latch_write_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          v0 = 1'b0;
  logic          v1 = 1'b0;
  logic [AW-1:0] a0 = '0;
  logic [AW-1:0] a1 = '0;
  logic [DW-1:0] d0 = '0;
  logic [DW-1:0] d1 = '0;

  wire [1:0]    rdy0;
  wire [1:0]    rdy1;
  wire [1:0]    en;
  wire [1:0]    busy;
  wire [1:0]    gnt;
  wire [AW-1:0] ba0;
  wire [AW-1:0] ba1;
  wire [DW-1:0] bd0;
  wire [DW-1:0] bd1;

  always #5 clock = ~clock;

  latch_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .EN_CYCLES(1)) dut_a (
    .clock(clock), .reset(reset),
    .io_req0_valid(v0), .io_req0_ready(rdy0[0]), .io_req0_addr(a0), .io_req0_data(d0),
    .io_req1_valid(v1), .io_req1_ready(rdy1[0]), .io_req1_addr(a1), .io_req1_data(d1),
    .io_bank_addr(ba0), .io_bank_data(bd0), .io_bank_enable(en[0]),
    .io_busy(busy[0]), .io_grant(gnt[0])
  );

  latch_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .EN_CYCLES(3)) dut_b (
    .clock(clock), .reset(reset),
    .io_req0_valid(v0), .io_req0_ready(rdy0[1]), .io_req0_addr(a0), .io_req0_data(d0),
    .io_req1_valid(v1), .io_req1_ready(rdy1[1]), .io_req1_addr(a1), .io_req1_data(d1),
    .io_bank_addr(ba1), .io_bank_data(bd1), .io_bank_enable(en[1]),
    .io_busy(busy[1]), .io_grant(gnt[1])
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: t = cycles since accept (0 = idle); a write spans t = 1 .. len+2.
  int            en_len [2] = '{1, 3};
  int            t      [2] = '{0, 0};
  bit            fav    [2] = '{1'b0, 1'b0};
  bit            mg     [2] = '{1'b0, 1'b0};
  logic [AW-1:0] ma     [2] = '{'0, '0};
  logic [DW-1:0] md     [2] = '{'0, '0};

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h t=%0d", tag, k, obs, exp, t[k]);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      bit  idle_req;
      bit  exp_r0;
      bit  exp_r1;
      bit  exp_en;
      idle_req = reset && (t[k] == 0) && (v0 || v1);
      exp_r0   = idle_req && v0 && (!v1 || !fav[k]);
      exp_r1   = idle_req && v1 && (!v0 || fav[k]);
      exp_en   = (t[k] >= 2) && (t[k] <= en_len[k] + 1);
      chk("ready0", k, 32'(rdy0[k]), 32'(exp_r0));
      chk("ready1", k, 32'(rdy1[k]), 32'(exp_r1));
      chk("enable", k, 32'(en[k]), 32'(exp_en));
      chk("busy",   k, 32'(busy[k]), 32'(t[k] != 0));
      chk("grant",  k, 32'(gnt[k]), 32'(mg[k]));
      chk("addr",   k, 32'(k == 1 ? ba1 : ba0), 32'(ma[k]));
      chk("data",   k, 32'(k == 1 ? bd1 : bd0), 32'(md[k]));
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        t[k] = 0; fav[k] = 1'b0; mg[k] = 1'b0; ma[k] = '0; md[k] = '0;
      end else if (t[k] == 0) begin
        if (v0 || v1) begin
          bit g;
          g      = (v0 && v1) ? fav[k] : v1;
          mg[k]  = g;
          ma[k]  = g ? a1 : a0;
          md[k]  = g ? d1 : d0;
          fav[k] = ~g;
          t[k]   = 1;
        end
      end else begin
        t[k] = (t[k] == en_len[k] + 2) ? 0 : t[k] + 1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    check_all();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  initial begin
    // First edge brings both DUTs out of X under reset; nothing to check yet.
    v0 = 1'b1; a0 = 2'd1; d0 = 8'hA5;
    @(posedge clock);
    model_edge();
    #1;

    // Reset held with a request pending: readies must stay low.
    cycle();
    cycle();

    // Single write from req0: addr 1, data 0xA5.
    reset = 1'b1;
    cycle();
    v0 = 1'b0;
    for (int i = 0; i < 8; i++) cycle();

    // Fresh pointer, both valid continuously: grants alternate 0,1,0,1.
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    v0 = 1'b1; a0 = 2'd0; d0 = 8'h11;
    v1 = 1'b1; a1 = 2'd3; d1 = 8'h22;
    for (int i = 0; i < 24; i++) cycle();

    // Reset while in ENABLE, then both valid: req0 must win.
    v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    v0 = 1'b1; a0 = 2'd2; d0 = 8'h3C;
    cycle();
    v0 = 1'b0;
    cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    v0 = 1'b1; v1 = 1'b1; d0 = 8'h44; d1 = 8'h55;
    cycle();
    v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < 8; i++) cycle();

    // req1 alone after req1 was last granted; req0 data churns mid-write.
    v1 = 1'b1; a1 = 2'd2; d1 = 8'h5A;
    cycle();
    v1 = 1'b0;
    for (int i = 0; i < 8; i++) cycle();
    v1 = 1'b1; a1 = 2'd3; d1 = 8'h77;
    cycle();
    v1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v0 = 1'b1;
      d0 = 8'($urandom);
      a0 = 2'($urandom);
      cycle();
    end
    v0 = 1'b0;
    for (int i = 0; i < 8; i++) cycle();

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 49) != 0);
      v0    = 1'($urandom_range(0, 1));
      v1    = 1'($urandom_range(0, 1));
      a0    = 2'($urandom);
      a1    = 2'($urandom);
      d0    = 8'($urandom);
      d1    = 8'($urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
